id_ex_pipe_reg: RTL

//  Parametrised ID->EX pipeline register with valid/ready handshake, flush and optional skid buffer.

---
 rtl/id_ex_pipe_reg_pkg.sv | 24 ++
 rtl/id_ex_pipe_reg_if.sv | 46 ++++
 rtl/id_ex_payload_slot.sv | 30 +++
 rtl/id_ex_pipe_reg.sv | 135 +++++++++++++
 4 files changed

// File: rtl/id_ex_pipe_reg_pkg.sv
// Purpose: shared widths, opcode constants and slot state encoding for the ID->EX register.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package id_ex_pipe_reg_pkg;

  localparam int ALUOP_W_DEF    = 8;
  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Opcode the payload register holds out of reset.
  localparam logic [7:0] ALUOP_NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } slot_state_e;

  // Packed payload: {aluop, rs, rt, w_reg_addr, wd, next_in_delayslot, now_in_delayslot}.
  function automatic int payload_w(input int aluop_w, input int data_w, input int reg_addr_w);
    return aluop_w + 2 * data_w + reg_addr_w + 3;
  endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// Purpose: ID->EX handshake and payload bundle; slave modport is the pipeline register side.
// Latency: n/a (wires only).
// Backpressure: id_valid/id_ready on the ID side, ex_valid/ex_ready on the EX side.
interface id_ex_pipe_reg_if import id_ex_pipe_reg_pkg::*; #(
  parameter int ALUOP_W    = ALUOP_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) ();

  logic                  id_valid;
  logic                  id_ready;
  logic [ALUOP_W-1:0]    id_aluop;
  logic [DATA_W-1:0]     id_rs_data;
  logic [DATA_W-1:0]     id_rt_data;
  logic [REG_ADDR_W-1:0] id_w_reg_addr;
  logic                  id_wd;
  logic                  id_next_in_delayslot;
  logic                  id_now_in_delayslot;

  logic                  ex_valid;
  logic                  ex_ready;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic [DATA_W-1:0]     ex_rs_data;
  logic [DATA_W-1:0]     ex_rt_data;
  logic [REG_ADDR_W-1:0] ex_w_reg_addr;
  logic                  ex_wd;
  logic                  ex_next_in_delayslot;
  logic                  ex_now_in_delayslot;

  // Environment side: drives ID beats and EX ready.
  modport master (
    output id_valid, id_aluop, id_rs_data, id_rt_data, id_w_reg_addr, id_wd,
           id_next_in_delayslot, id_now_in_delayslot, ex_ready,
    input  id_ready, ex_valid, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
           ex_next_in_delayslot, ex_now_in_delayslot
  );

  // Pipeline register side.
  modport slave (
    input  id_valid, id_aluop, id_rs_data, id_rt_data, id_w_reg_addr, id_wd,
           id_next_in_delayslot, id_now_in_delayslot, ex_ready,
    output id_ready, ex_valid, ex_aluop, ex_rs_data, ex_rt_data, ex_w_reg_addr, ex_wd,
           ex_next_in_delayslot, ex_now_in_delayslot
  );

endinterface

// File: rtl/id_ex_payload_slot.sv
// Purpose: one payload register; loads on load, kill clears only the write-back enable bit.
// Latency: 1 cycle from load to q.
// Backpressure: none; the owner decides when to load.
// Ports: clk, rst (sync, active-high), load, kill, d -> q.
module id_ex_payload_slot #(
  parameter int           W       = 8,
  parameter int           WD_BIT  = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         kill,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // kill beats load: a beat offered during a flush must not land here,
  // and whatever is held can no longer write back.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (kill) begin
      q[WD_BIT] <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// Purpose: ID->EX pipeline register with valid/ready handshake, flush-kill and optional skid entry.
// Latency: 1 cycle from accept to ex_valid when the main slot is empty or being consumed.
// Backpressure: default build id_ready = !ex_valid || ex_ready; with ID_EX_SKID_EN id_ready = !skid_valid.
// Ports: clk, rst (sync, active-high), flush, bus (id_ex_pipe_reg_if.slave: id_* in, ex_* out).
// Build option: define ID_EX_SKID_EN to add the skid entry and cut the ex_ready->id_ready path.
module id_ex_pipe_reg import id_ex_pipe_reg_pkg::*; #(
  parameter int ALUOP_W    = ALUOP_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  id_ex_pipe_reg_if.slave bus
);

  localparam int PAY_W  = payload_w(ALUOP_W, DATA_W, REG_ADDR_W);
  localparam int WD_BIT = 2;
  // NOP opcode in the aluop field, every other bit zero.
  localparam logic [PAY_W-1:0] RST_PAY = PAY_W'(ALUOP_NOP) << (PAY_W - ALUOP_W);

  slot_state_e      state_q, state_d;
  logic             accept, consume;
  logic             main_load;
  logic [PAY_W-1:0] id_pay, main_d, main_q;

  assign id_pay = {bus.id_aluop, bus.id_rs_data, bus.id_rt_data, bus.id_w_reg_addr,
                   bus.id_wd, bus.id_next_in_delayslot, bus.id_now_in_delayslot};

  assign accept   = bus.id_valid && bus.id_ready;
  assign consume  = bus.ex_valid && bus.ex_ready;
  assign bus.ex_valid = (state_q != ST_EMPTY);

`ifdef ID_EX_SKID_EN
  logic             skid_load;
  logic [PAY_W-1:0] skid_q;

  // Depends only on state and rst, so EX readiness never ripples back to ID in the same cycle.
  assign bus.id_ready = !rst && (state_q != ST_SKID);
  // Draining the skid entry refills main from skid; otherwise main takes the incoming beat.
  assign main_d       = (state_q == ST_SKID) ? skid_q : id_pay;
`else
  assign bus.id_ready = !rst && (!bus.ex_valid || bus.ex_ready);
  assign main_d       = id_pay;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
`ifdef ID_EX_SKID_EN
    skid_load = 1'b0;
`endif
    if (flush) begin
      // A consume in this cycle still completes on the EX side; nothing new is kept.
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
`ifdef ID_EX_SKID_EN
          if (accept && consume) begin
            main_load = 1'b1;
          end else if (accept) begin
            state_d   = ST_SKID;
            skid_load = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
`else
          // Without skid, accept in FULL implies consume (id_ready needs ex_ready).
          if (accept) begin
            main_load = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
`endif
        end
`ifdef ID_EX_SKID_EN
        ST_SKID: begin
          if (consume) begin
            state_d   = ST_FULL;
            main_load = 1'b1;
          end
        end
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  id_ex_payload_slot #(
    .W       (PAY_W),
    .WD_BIT  (WD_BIT),
    .RST_VAL (RST_PAY)
  ) u_main_slot (
    .clk  (clk),
    .rst  (rst),
    .load (main_load),
    .kill (flush),
    .d    (main_d),
    .q    (main_q)
  );

`ifdef ID_EX_SKID_EN
  id_ex_payload_slot #(
    .W       (PAY_W),
    .WD_BIT  (WD_BIT),
    .RST_VAL (RST_PAY)
  ) u_skid_slot (
    .clk  (clk),
    .rst  (rst),
    .load (skid_load),
    .kill (flush),
    .d    (id_pay),
    .q    (skid_q)
  );
`endif

  assign {bus.ex_aluop, bus.ex_rs_data, bus.ex_rt_data, bus.ex_w_reg_addr,
          bus.ex_wd, bus.ex_next_in_delayslot, bus.ex_now_in_delayslot} = main_q;

endmodule
